// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, instruction size and the
// program-counter controller state encoding.
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } pc_state_e;

endpackage : cpu_pkg

// File: rtl/pc_target_calc.sv
// Redirect target calculation for branches, JAL and JALR, plus the
// misaligned-target flag (bit 1 set means not 4-byte aligned).
module pc_target_calc
  import cpu_pkg::*;
(
  input  logic            is_jalr,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic            misaligned_tgt
);

  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_pc_rel_sum;

  // JALR clears bit 0 of its sum; PC-relative targets use the sum as-is.
  always_comb begin
    w_jalr_sum     = jalr_base + imm;
    w_pc_rel_sum   = branch_pc + imm;
    target         = is_jalr ? (w_jalr_sum & ~XLEN'(1)) : w_pc_rel_sum;
    misaligned_tgt = target[1];
  end

endmodule : pc_target_calc

// File: rtl/pc_unit.sv
// Program counter and redirect controller: sequential fetch, taken-branch
// and jump redirects with a multi-cycle flush, misaligned-target trap and
// a saturating redirect counter.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_PC      = 32'h0000_0100,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            is_branch,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            trap_clear,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic            flush,
  output logic            misaligned,
  output logic [15:0]     redirect_count
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  pc_state_e       r_state;
  pc_state_e       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [3:0]      r_flush_cnt;
  logic [3:0]      w_flush_cnt_nxt;
  logic            r_redirect;
  logic            w_redirect_nxt;
  logic [15:0]     r_redirect_count;
  logic            w_count_inc;
  logic            w_take;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned_tgt;

  pc_target_calc u_target (
    .is_jalr        (is_jalr),
    .branch_pc      (branch_pc),
    .jalr_base      (jalr_base),
    .imm            (imm),
    .target         (w_target),
    .misaligned_tgt (w_misaligned_tgt)
  );

  // Redirect request from EX and the sequential next address.
  always_comb begin
    w_take   = (is_branch & branch_taken) | jump;
    pc_plus4 = r_pc + XLEN'(INSN_BYTES);
  end

  // Next-state, next-PC and flush-counter decisions for each state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_flush_cnt_nxt = r_flush_cnt;
    w_redirect_nxt  = 1'b0;
    w_count_inc     = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_take && w_misaligned_tgt) begin
          w_state_nxt = TRAP;
        end else if (w_take) begin
          w_pc_nxt        = w_target;
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
          w_redirect_nxt  = 1'b1;
          w_count_inc     = 1'b1;
        end else if (!stall) begin
          w_pc_nxt = pc_plus4;
        end
      end
      FLUSH: begin
        // The EX instruction is being killed, so its branch/jump is ignored.
        if (!stall) begin
          w_pc_nxt        = pc_plus4;
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          if (r_flush_cnt == 4'd1) w_state_nxt = RUN;
        end
      end
      TRAP: begin
        if (trap_clear) begin
          w_pc_nxt    = TRAP_PC;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State, PC, flush counter and redirect pulse registers.
  // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
  // clears everything mid-FLUSH or mid-TRAP without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_pc        <= RESET_PC;
      r_flush_cnt <= 4'd0;
      r_redirect  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_redirect  <= w_redirect_nxt;
    end
  end

  // Saturating count of taken redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_count <= 16'd0;
    end else if (w_count_inc && (r_redirect_count != 16'hFFFF)) begin
      r_redirect_count <= r_redirect_count + 16'd1;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    pc             = r_pc;
    redirect       = r_redirect;
    flush          = (r_state == FLUSH) || (r_state == TRAP);
    misaligned     = (r_state == TRAP);
    redirect_count = r_redirect_count;
  end

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        is_branch;
  logic        branch_taken;
  logic        jump;
  logic        is_jalr;
  logic [31:0] branch_pc;
  logic [31:0] imm;
  logic [31:0] jalr_base;
  logic        trap_clear;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        flush;
  logic        misaligned;
  logic [15:0] redirect_count;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit #(
    .RESET_PC     (32'h0000_0000),
    .TRAP_PC      (32'h0000_0100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .is_branch      (is_branch),
    .branch_taken   (branch_taken),
    .jump           (jump),
    .is_jalr        (is_jalr),
    .branch_pc      (branch_pc),
    .imm            (imm),
    .jalr_base      (jalr_base),
    .trap_clear     (trap_clear),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .redirect       (redirect),
    .flush          (flush),
    .misaligned     (misaligned),
    .redirect_count (redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; is_branch = 0; branch_taken = 0; jump = 0; is_jalr = 0;
    branch_pc = '0; imm = '0; jalr_base = '0; trap_clear = 0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_red,
                           input logic e_flush, input logic e_mis);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".redirect"}, {31'b0, redirect}, {31'b0, e_red});
    chk({tag, ".flush"}, {31'b0, flush}, {31'b0, e_flush});
    chk({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, e_mis});
  endtask

  // Unconditional JAL redirect to an aligned target, then ride out the flush.
  task automatic jal_to(input logic [31:0] tgt);
    jump = 1; branch_pc = tgt; imm = 32'h0;
    tick();
    idle();
    tick();
    tick();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    // Reset state
    chk_state("reset", 32'h0, 0, 0, 0);
    chk("reset.pc_plus4", pc_plus4, 32'h4);
    chk("reset.count", {16'b0, redirect_count}, 32'h0);
    rst = 0;

    // Sequential fetch
    tick(); tick(); tick();
    chk_state("seq3", 32'h0C, 0, 0, 0);

    // Taken branch 0x40 + (-16) = 0x30
    is_branch = 1; branch_taken = 1; branch_pc = 32'h40; imm = 32'hFFFF_FFF0;
    tick();
    idle();
    chk_state("br.take", 32'h30, 1, 1, 0);
    chk("br.count", {16'b0, redirect_count}, 32'd1);
    tick();
    chk_state("br.flush2", 32'h34, 0, 1, 0);
    tick();
    chk_state("br.run", 32'h38, 0, 0, 0);

    // Not-taken branch advances without flush
    is_branch = 1; branch_taken = 0; branch_pc = 32'h200; imm = 32'h40;
    tick();
    idle();
    chk_state("nt", 32'h3C, 0, 0, 0);

    // Stall holds for 3 cycles
    stall = 1;
    tick(); tick(); tick();
    chk_state("stall3", 32'h3C, 0, 0, 0);

    // Take overrides stall: JAL 0x70 + 0x10 = 0x80
    jump = 1; branch_pc = 32'h70; imm = 32'h10;
    tick();
    idle();
    chk_state("stall.jal", 32'h80, 1, 1, 0);
    chk("stall.jal.count", {16'b0, redirect_count}, 32'd2);
    tick(); tick();
    chk_state("stall.jal.run", 32'h88, 0, 0, 0);

    // JALR (0x101 + 3) & ~1 = 0x104
    jump = 1; is_jalr = 1; jalr_base = 32'h101; imm = 32'h3; branch_pc = 32'h999;
    tick();
    idle();
    chk_state("jalr", 32'h104, 1, 1, 0);
    // One stall during FLUSH extends it
    stall = 1;
    tick();
    chk_state("jalr.stall", 32'h104, 0, 1, 0);
    // Branch presented during FLUSH is ignored
    stall = 0; is_branch = 1; branch_taken = 1; branch_pc = 32'h200; imm = 32'h100;
    tick();
    idle();
    chk_state("jalr.fl.br", 32'h108, 0, 1, 0);
    tick();
    chk_state("jalr.run", 32'h10C, 0, 0, 0);
    chk("jalr.count", {16'b0, redirect_count}, 32'd3);

    // Misaligned JAL 0x10 + 2 = 0x12 traps, pc held
    jump = 1; branch_pc = 32'h10; imm = 32'h2;
    tick();
    chk_state("trap.enter", 32'h10C, 0, 1, 1);
    chk("trap.count", {16'b0, redirect_count}, 32'd3);
    // Take and stall ignored while trapped
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      tick();
    end
    idle();
    chk_state("trap.hold5", 32'h10C, 0, 1, 1);
    trap_clear = 1;
    tick();
    idle();
    chk_state("trap.clear", 32'h100, 0, 0, 0);
    // trap_clear in RUN has no effect
    trap_clear = 1;
    tick();
    idle();
    chk_state("clr.in.run", 32'h104, 0, 0, 0);

    // Reset mid-TRAP clears asynchronously
    jump = 1; branch_pc = 32'h10; imm = 32'h6;
    tick();
    idle();
    chk_state("trap2", 32'h104, 0, 1, 1);
    #2 rst = 1;
    #1;
    chk_state("arst", 32'h0, 0, 0, 0);
    chk("arst.count", {16'b0, redirect_count}, 32'h0);
    chk("arst.pc_plus4", pc_plus4, 32'h4);
    tick();
    rst = 0;

    // Wrap: JAL to 0xFFFF_FFF4, flush to 0xFFFF_FFFC in RUN, then 0
    jump = 1; branch_pc = 32'h0; imm = 32'hFFFF_FFF4;
    tick();
    idle();
    chk_state("wrap.jal", 32'hFFFF_FFF4, 1, 1, 0);
    tick(); tick();
    chk_state("wrap.top", 32'hFFFF_FFFC, 0, 0, 0);
    chk("wrap.pc_plus4", pc_plus4, 32'h0);
    tick();
    chk_state("wrap.zero", 32'h0, 0, 0, 0);

    // Saturation: preload the counter near full, then redirect past it
    force dut.r_redirect_count = 16'hFFFD;
    #1;
    release dut.r_redirect_count;
    jal_to(32'h40);
    chk("sat.fffe", {16'b0, redirect_count}, 32'h0000_FFFE);
    jal_to(32'h80);
    chk("sat.ffff", {16'b0, redirect_count}, 32'h0000_FFFF);
    jal_to(32'hC0);
    chk("sat.hold", {16'b0, redirect_count}, 32'h0000_FFFF);
    chk_state("sat.pc", 32'hC8, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pc_unit
